// File: rtl/matrix_print_mode.sv
// Streams a stored M x N matrix from BRAM to the UART as unsigned decimal ASCII,
// row-major, space-separated with CR/LF at the end of each row.
module matrix_print_mode #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [3:0]               dim_m,
    input  logic [3:0]               dim_n,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_LATCH, S_CONV_H, S_CONV_T,
        S_SEND, S_WAIT_HI, S_WAIT_LO
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [3:0]            r_m;
    logic [3:0]            r_n;
    logic [3:0]            r_row;
    logic [3:0]            r_col;
    logic [7:0]            r_val;
    logic [1:0]            r_hund;
    logic [3:0]            r_tens;
    logic [2:0]            r_phase;

    logic [7:0] w_data_ext;
    logic [7:0] w_byte;
    logic       w_skip;
    logic       w_last_col;
    logic       w_last_row;
    logic       w_elem_end;

    always_comb begin
        w_data_ext = '0;
        w_data_ext[ELEMENT_WIDTH-1:0] = mem_rd_data;
    end

    assign w_last_col = (r_col == r_n - 4'd1);
    assign w_last_row = (r_row == r_m - 4'd1);
    // Phase 3 ends the element unless it was the CR of a row end, which needs the LF.
    assign w_elem_end = (r_phase == 3'd4) || (r_phase == 3'd3 && !w_last_col);

    // Byte sequence per element: hundreds, tens, units, separator, LF; leading zeros skipped.
    always_comb begin
        w_byte = 8'h00;
        w_skip = 1'b1;
        case (r_phase)
            3'd0: begin w_byte = 8'h30 + {6'd0, r_hund}; w_skip = (r_hund == 2'd0); end
            3'd1: begin w_byte = 8'h30 + {4'd0, r_tens}; w_skip = (r_hund == 2'd0) && (r_tens == 4'd0); end
            3'd2: begin w_byte = 8'h30 + {4'd0, r_val[3:0]}; w_skip = 1'b0; end
            3'd3: begin w_byte = w_last_col ? 8'h0D : 8'h20; w_skip = 1'b0; end
            3'd4: begin w_byte = 8'h0A; w_skip = !w_last_col; end
            default: begin w_byte = 8'h00; w_skip = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_idx       <= '0;
            r_m         <= '0;
            r_n         <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_val       <= '0;
            r_hund      <= '0;
            r_tens      <= '0;
            r_phase     <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else if (!enable) begin
            r_state   <= S_IDLE;
            mem_rd_en <= 1'b0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (dim_m == 4'd0 || dim_n == 4'd0) begin
                            error <= 1'b1;
                        end else begin
                            r_base      <= base_addr;
                            r_m         <= dim_m;
                            r_n         <= dim_n;
                            r_row       <= '0;
                            r_col       <= '0;
                            r_idx       <= '0;
                            busy        <= 1'b1;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= base_addr;
                            r_state     <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ:  r_state <= S_RD_WAIT;
                S_RD_WAIT: r_state <= S_LATCH;
                S_LATCH: begin
                    r_val     <= w_data_ext;
                    r_hund    <= '0;
                    r_tens    <= '0;
                    mem_rd_en <= 1'b0;
                    r_state   <= S_CONV_H;
                end
                S_CONV_H: begin
                    if (r_val >= 8'd100) begin
                        r_val  <= r_val - 8'd100;
                        r_hund <= r_hund + 2'd1;
                    end else begin
                        r_state <= S_CONV_T;
                    end
                end
                S_CONV_T: begin
                    if (r_val >= 8'd10) begin
                        r_val  <= r_val - 8'd10;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_phase <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_skip) begin
                        r_phase <= r_phase + 3'd1;
                    end else if (!tx_busy) begin
                        tx_data  <= w_byte;
                        tx_start <= 1'b1;
                        r_state  <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) r_state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (!w_elem_end) begin
                            r_phase <= r_phase + 3'd1;
                            r_state <= S_SEND;
                        end else if (w_last_col && w_last_row) begin
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            if (w_last_col) begin
                                r_col <= '0;
                                r_row <= r_row + 4'd1;
                            end else begin
                                r_col <= r_col + 4'd1;
                            end
                            r_idx       <= r_idx + ADDR_WIDTH'(1);
                            mem_rd_addr <= r_base + r_idx + ADDR_WIDTH'(1);
                            mem_rd_en   <= 1'b1;
                            r_state     <= S_RD_REQ;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_print_mode.sv
// Scoreboard bench for matrix_print_mode: expected bytes/addresses are queued by the
// stimulus and popped by a monitor on each tx_start / read request.
module tb_matrix_print_mode;

    localparam int AW = 10;
    localparam int UART_LEN = 5;

    logic          clk = 1'b0;
    logic          rst, enable, start;
    logic [AW-1:0] base_addr;
    logic [3:0]    dim_m, dim_n;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic [7:0]    tx_data;
    logic          tx_start, tx_busy;
    logic          busy, done, error;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    r_d1;
    int unsigned   uart_cnt;
    logic          hold;

    logic [7:0]    exp_q [$];
    logic [AW-1:0] addr_q [$];
    int            total = 0;
    int            passed = 0;
    int            tx_count = 0;
    int            rd_count = 0;
    logic          prev_en = 1'b0;

    matrix_print_mode #(.ELEMENT_WIDTH(8), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start),
        .base_addr(base_addr), .dim_m(dim_m), .dim_n(dim_n),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Two-stage BRAM: data for an address is valid on the 2nd edge after it is driven.
    always @(posedge clk) begin
        r_d1        <= mem[mem_rd_addr];
        mem_rd_data <= r_d1;
    end

    always @(posedge clk) begin
        if (rst) uart_cnt <= 0;
        else if (tx_start && uart_cnt == 0) uart_cnt <= UART_LEN;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end
    assign tx_busy = (uart_cnt != 0) || hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (tx_start) begin
            tx_count++;
            check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_q.size() == 0) check("unexpected_tx_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
            else check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
        end
        if (mem_rd_en && !prev_en) begin
            if (addr_q.size() == 0) check("unexpected_read", {22'd0, mem_rd_addr}, 32'hFFFF_FFFF);
            else check("rd_addr", {22'd0, mem_rd_addr}, {22'd0, addr_q.pop_front()});
        end
        if (mem_rd_en) rd_count++;
        prev_en = mem_rd_en;
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic push_addrs(input logic [AW-1:0] base, input int count);
        for (int i = 0; i < count; i++) addr_q.push_back(base + AW'(i));
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [3:0] m, input logic [3:0] n);
        @(negedge clk);
        base_addr = b; dim_m = m; dim_n = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check({name, "_done"}, {31'd0, seen}, 32'd1);
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({name, "_bytes_left"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_tx(input int target);
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (tx_count >= target) break;
        end
        #1;
    endtask

    task automatic run_2x3(input string name);
        int c0;
        c0 = tx_count;
        push_str("1 2 3\r\n4 5 6\r\n");
        push_addrs(10'h010, 6);
        do_start(10'h010, 4'd2, 4'd3);
        wait_done(name);
        check({name, "_tx_pulses"}, tx_count - c0, 32'd14);
    endtask

    task automatic abort_and_rerun(input bit use_rst);
        int c0;
        c0 = tx_count;
        push_str("1 2 3\r\n4 5 6\r\n");
        push_addrs(10'h010, 6);
        do_start(10'h010, 4'd2, 4'd3);
        wait_tx(c0 + 3);
        if (use_rst) rst = 1'b1; else enable = 1'b0;
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_tx_start", {31'd0, tx_start}, 32'd0);
        check("abort_rd_en", {31'd0, mem_rd_en}, 32'd0);
        if (use_rst) begin
            check("abort_tx_data", {24'd0, tx_data}, 32'd0);
            check("abort_rd_addr", {22'd0, mem_rd_addr}, 32'd0);
        end
        c0 = tx_count;
        repeat (10) @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_more_tx", tx_count - c0, 32'd0);
        run_2x3(use_rst ? "rerun_after_rst" : "rerun_after_enable");
    endtask

    initial begin
        int c0, r0;
        rst = 1'b1; enable = 1'b1; start = 1'b0; hold = 1'b0;
        base_addr = '0; dim_m = '0; dim_n = '0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        for (int i = 0; i < 6; i++) mem[16 + i] = 8'(i + 1);
        mem[10'h100] = 8'd255; mem[10'h101] = 8'd0; mem[10'h102] = 8'd10;
        mem[10'h3FF] = 8'd7;   mem[10'h000] = 8'd42;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_rd_addr", {22'd0, mem_rd_addr}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_2x3("print_2x3");

        push_str("255 0 10\r\n");
        push_addrs(10'h100, 3);
        do_start(10'h100, 4'd1, 4'd3);
        wait_done("print_1x3");

        c0 = tx_count; r0 = rd_count;
        do_start(10'h020, 4'd0, 4'd4);
        check("err_pulse", {31'd0, error}, 32'd1);
        check("err_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("err_one_cycle", {31'd0, error}, 32'd0);
        repeat (5) @(negedge clk);
        check("err_no_tx", tx_count - c0, 32'd0);
        check("err_no_rd", rd_count - r0, 32'd0);
        check("err_busy_after", {31'd0, busy}, 32'd0);

        push_str("7 42\r\n");
        addr_q.push_back(10'h3FF);
        addr_q.push_back(10'h000);
        do_start(10'h3FF, 4'd1, 4'd2);
        wait_done("addr_wrap");

        c0 = tx_count;
        push_str("255 0 10\r\n");
        push_addrs(10'h100, 3);
        do_start(10'h100, 4'd1, 4'd3);
        wait_tx(c0 + 1);
        hold = 1'b1;
        repeat (200) @(negedge clk);
        check("hold_no_tx", tx_count - c0, 32'd1);
        check("hold_busy", {31'd0, busy}, 32'd1);
        hold = 1'b0;
        wait_done("hold_print");

        abort_and_rerun(1'b1);
        abort_and_rerun(1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/matrix_print_mode.md
Name: matrix_print_mode

Overview:
- Reads a stored matrix (base address plus M×N) out of matrix BRAM in row-major order.
- Formats each element as unsigned decimal ASCII and streams it byte by byte to the UART transmitter.
- This is the read-back/print counterpart of the matrix input path. It is used by display and result-output modes after a matrix has been committed.

Parameters:
- ELEMENT_WIDTH, 8, element data width; unsigned; must be ≤ 8.
- ADDR_WIDTH, 10, BRAM address width.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  mode active; low forces IDLE
- start  input  1  one-cycle pulse; begin printing
- base_addr  input  ADDR_WIDTH  address of element (0,0)
- dim_m  input  4  row count
- dim_n  input  4  column count
- mem_rd_en  output  1  BRAM read enable
- mem_rd_addr  output  ADDR_WIDTH  BRAM read address
- mem_rd_data  input  ELEMENT_WIDTH  BRAM read data
- tx_data  output  8  byte to UART
- tx_start  output  1  one-cycle send pulse
- tx_busy  input  1  UART transmitter busy
- busy  output  1  high from accepted start until done/error
- done  output  1  one-cycle pulse, print complete
- error  output  1  one-cycle pulse, start rejected

Behaviour:
- Reset (rst=1 at a clk edge): all outputs are 0 and state is IDLE. This holds even mid-print: a transfer in progress is dropped without a trailing CR/LF.
- enable=0: next edge goes to IDLE; tx_start, mem_rd_en, busy, done and error are all 0. Registered tx_data and mem_rd_addr hold.
- IDLE: on start with enable=1:
  - dim_m=0 or dim_n=0 → error=1 for 1 cycle; no reads, no tx.
  - Otherwise latch base_addr/dim_m/dim_n, clear row/col/index, set busy, go RD_REQ.
  - start while busy is ignored.
- RD_REQ: mem_rd_en=1, mem_rd_addr = base + idx, computed modulo 2^ADDR_WIDTH (wraps past max address). mem_rd_en stays 1 from RD_REQ through LATCH, 0 otherwise.
- RD_WAIT: one cycle.
- LATCH: capture mem_rd_data, zero-extended to 8 bits. Data is valid on the 2nd edge after the address is driven.
- CONV: sequential decimal conversion, no divider.
  - Hundreds: subtract 100 per cycle while the value is ≥ 100 (at most 2 cycles).
  - Tens: subtract 10 per cycle (at most 9 cycles). The remainder is the units digit.
  - Emit digits most-significant first with leading zeros suppressed; value 0 prints "0".
- SEND: each byte uses the TX handshake below; digits first, then a separator.
  - Separator is 0x20 if col < n−1.
  - At col = n−1 the separator is 0x0D then 0x0A.
  - Counters then advance: col++, or col=0 and row++.
- After the last element's 0x0A → done=1 for 1 cycle, busy=0, IDLE. Output has no header and no trailing space.
- TX handshake, per byte:
  - Drive tx_data and pulse tx_start for exactly 1 cycle, only when tx_busy=0.
  - Then wait until tx_busy has been observed 1 and subsequently 0 before the next byte.
  - tx_data is stable from the pulse until the next pulse.
- Never more than one tx_start per byte. A byte is never dropped while tx_busy is held high.
- Simultaneous start and enable falling: enable wins, no start accepted.

Test Plan:
- 2×3 at base 0x010, contents 1,2,3,4,5,6; UART model busy 5 cycles per byte → bytes "1 2 3\r\n4 5 6\r\n" (14 tx_start pulses); then done pulse; busy low.
- 1×3 with contents 255,0,10 → "255 0 10\r\n"; check 3 digits for 255 and single "0".
- start with dim_m=0, dim_n=4 → error pulse one cycle after start; zero mem_rd_en and zero tx_start; busy stays 0.
- base_addr=0x3FF, 1×2 → mem_rd_addr 0x3FF then 0x000 (wrap); output matches BRAM contents.
- Hold tx_busy=1 for 200 cycles after the first byte → no further tx_start until tx_busy falls; the full string is still intact.
- Mid-print, assert rst (or drop enable) → next edge all outputs 0 and no further tx_start. A new start after release prints the full matrix from (0,0).
